// File: rtl/bitwise_logic_pkg.sv
// rtl/bitwise_logic_pkg.sv - shared op codes and widths for the bitwise logic unit
package bitwise_logic_pkg;

    localparam int BLU_OP_W = 3;

    typedef enum logic [BLU_OP_W-1:0] {
        BLU_AND   = 3'd0,
        BLU_NAND  = 3'd1,
        BLU_OR    = 3'd2,
        BLU_NOR   = 3'd3,
        BLU_XOR   = 3'd4,
        BLU_XNOR  = 3'd5,
        BLU_NOT_A = 3'd6,
        BLU_PASS_B = 3'd7
    } blu_op_e;

endpackage

// File: rtl/blu_op_core.sv
// rtl/blu_op_core.sv - combinational bitwise op decode with zero/ones/parity flags
module blu_op_core
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [BLU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                ones,
    output logic                parity
);

    // Select the bitwise function; results never extend beyond WIDTH bits
    always_comb begin
        result = '0;
        case (blu_op_e'(op))
            BLU_AND:    result = a & b;
            BLU_NAND:   result = ~(a & b);
            BLU_OR:     result = a | b;
            BLU_NOR:    result = ~(a | b);
            BLU_XOR:    result = a ^ b;
            BLU_XNOR:   result = ~(a ^ b);
            BLU_NOT_A:  result = ~a;
            BLU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

    // Flags are derived from the same value so they travel with it through the registers
    always_comb begin
        zero   = (result == '0);
        ones   = &result;
        parity = ^result;
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - registered bitwise unit with accumulator and skid-buffered output
module bitwise_logic_unit
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit ACC_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                acc_sel,
    input  logic                acc_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                ones,
    output logic                parity
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_ones;
    logic             core_parity;

    // Output register (OR) and skid register (SK); flags packed as {zero, ones, parity}
    logic [WIDTH-1:0] or_data;
    logic [2:0]       or_flags;
    logic             or_valid;
    logic [WIDTH-1:0] sk_data;
    logic [2:0]       sk_flags;
    logic             sk_valid;
    logic             in_ready_q;

    logic accept;
    logic drain;
    logic load_or_new;
    logic load_sk_new;
    logic move_sk;
    logic or_valid_nxt;
    logic sk_valid_nxt;

    assign opnd_a = (ACC_EN && acc_sel) ? acc : a;

    blu_op_core #(.WIDTH(WIDTH)) u_core (
        .op     (op),
        .a      (opnd_a),
        .b      (b),
        .result (core_result),
        .zero   (core_zero),
        .ones   (core_ones),
        .parity (core_parity)
    );

    assign accept = in_valid && in_ready_q;
    assign drain  = or_valid && out_ready;

    // Decide where this cycle's result lands; accept only happens with SK empty
    always_comb begin
        load_or_new  = 1'b0;
        load_sk_new  = 1'b0;
        move_sk      = 1'b0;
        or_valid_nxt = or_valid;
        sk_valid_nxt = sk_valid;
        if (accept) begin
            if (!or_valid || out_ready) begin
                load_or_new  = 1'b1;
                or_valid_nxt = 1'b1;
            end else begin
                load_sk_new  = 1'b1;
                sk_valid_nxt = 1'b1;
            end
        end else if (drain) begin
            if (sk_valid) begin
                move_sk      = 1'b1;
                sk_valid_nxt = 1'b0;
            end else begin
                or_valid_nxt = 1'b0;
            end
        end
    end

    // Occupancy registers; in_ready is a registered copy of "SK will be empty"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_data    <= '0;
            or_flags   <= '0;
            or_valid   <= 1'b0;
            sk_data    <= '0;
            sk_flags   <= '0;
            sk_valid   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            or_valid   <= or_valid_nxt;
            sk_valid   <= sk_valid_nxt;
            in_ready_q <= !sk_valid_nxt;
            if (load_or_new) begin
                or_data  <= core_result;
                or_flags <= {core_zero, core_ones, core_parity};
            end else if (move_sk) begin
                or_data  <= sk_data;
                or_flags <= sk_flags;
            end
            if (load_sk_new) begin
                sk_data  <= core_result;
                sk_flags <= {core_zero, core_ones, core_parity};
            end
        end
    end

    generate
        if (ACC_EN) begin : g_acc
            // Accumulator follows every accepted result; a clear wins over the load
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                end else if (acc_clr) begin
                    acc <= '0;
                end else if (accept) begin
                    acc <= core_result;
                end
            end
        end else begin : g_no_acc
            assign acc = '0;
        end
    endgenerate

    assign in_ready  = in_ready_q;
    assign out_valid = or_valid;
    assign result    = or_data;
    assign zero      = or_flags[2];
    assign ones      = or_flags[1];
    assign parity    = or_flags[0];

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, pipelined successor to the team's fixed 16-bit AND/NAND gates: one registered bitwise unit covering eight logic operations selected per transaction, with an internal accumulator for chained operations and valid/ready flow control on both sides. Results come from an output register with a one-entry skid buffer, so the unit sustains one operation per cycle and tolerates downstream stalls. It sits in the ALU datapath beside the arithmetic units, and the ALU output mux consumes `result` and the flags.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- ACC_EN, 1, 1 = accumulator present; 0 = `acc_sel`/`acc_clr` ignored, accumulator tied to 0
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  transaction offered
- in_ready  out  1  unit can accept a transaction
- op  in  3  operation code (see Operation)
- a, b  in  WIDTH  operands
- acc_sel  in  1  1 = use accumulator in place of `a`
- acc_clr  in  1  synchronous accumulator clear
- out_valid  out  1  `result`/flags valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- ones  out  1  result == all ones
- parity  out  1  XOR-reduction of result (1 = odd popcount)

## Operation
- Op codes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A (~A), 7 PASS B. A = `acc_sel ? acc : a`.
- Accept when `in_valid && in_ready`. Compute the result combinationally from the inputs in that cycle. Compute flags from the same value and register them with it.
- All results are exactly WIDTH bits. There is no carry or extension.
- Accumulator: WIDTH-bit register, reset 0. Each accept loads the computed result. `acc_clr` loads 0 and takes priority over an accept in the same cycle. The accepted operation still reads the pre-clear `acc`, and its result is still emitted. `acc_clr` without an accept also clears.
- Storage: output register (OR) plus skid register (SK), each with a valid bit. Results leave strictly in accept order.
- Accept when OR is empty or drained this cycle (`out_ready`): the new result goes to OR.
- Accept while OR holds and `out_ready=0`: the new result goes to SK.
- OR drained with SK full: SK moves to OR in the same edge.
- Occupancy states: EMPTY (OR0,SK0), ONE (OR1,SK0), FULL (OR1,SK1).
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain with no accept.
  - ONE→FULL on accept with no drain.
  - ONE→ONE on accept and drain together.
  - FULL→ONE on drain. No accept is possible in FULL.
- `in_ready` is registered and equals `!SK.valid` after the edge. It is never combinationally dependent on `out_ready`.

## Timing
- Latency: accept at edge N, so `out_valid`/`result` are visible after edge N (first sampled at N+1). One-cycle latency.
- Throughput: 1 per cycle with `out_ready` held high. No bubbles.
- Reset values while `rst_n`=0:
  - `in_ready`=0 and `out_valid`=0.
  - `result`=0, `zero`=0, `ones`=0, `parity`=0.
  - SK empty and `acc`=0.
- `in_ready` rises at the first `clk` edge after `rst_n` deasserts.
- Reset mid-operation: OR and SK contents are discarded immediately (asynchronous), and `acc` clears.
- While `out_valid`=1 and `out_ready`=0, `result` and flags hold stable.
- `op`, `a`, `b`, `acc_sel` are don't-care when no accept occurs.

## Structure
- Shared package `bitwise_logic_pkg`:
  - enum `blu_op_e` (8 codes above);
  - constant `BLU_OP_W=3`.
- Sub-module `blu_op_core`: combinational WIDTH-parametrised op decode plus zero/ones/parity generation. The top level holds the accumulator, the OR/SK registers and the handshake.

## Test plan
- WIDTH=16, op AND, a=0xF0F0, b=0xFF00, `out_ready`=1 → next cycle `result`=0xF000, zero=0, ones=0, parity=0. Repeat with op NAND → 0x0FFF, parity=0.
- op NOR, a=0xFFFF, b=0x0000 → result 0x0000, zero=1. op XNOR, a=b=0x1234 → 0xFFFF, ones=1.
- Backpressure: `out_ready`=0, three back-to-back offers (AND 0x000F&0x00FF, OR 0x0F00|0x00F0, XOR 0xAAAA^0x5555).
  - Required: the first two are accepted and `in_ready` goes 0.
  - On raising `out_ready`, the sequence 0x000F, 0x0FF0, 0xFFFF appears on consecutive cycles.
  - No loss or duplication.
- Accumulate: `acc_clr` pulse, then XOR with `acc_sel`=1, b=0x0001, then b=0x0003 → results 0x0001, 0x0002. Then PASS B with `acc_clr` in the same cycle, b=0x00FF → result 0x00FF, acc=0.
- Streaming: 100 random ops with random `out_ready` → results match a reference model in order, and throughput is 1/cycle whenever `out_ready`=1.
- Async reset asserted mid-cycle in FULL state → `out_valid`=0 and `in_ready`=0 immediately. After release, the first accept with `acc_sel`=1, op OR, b=0 → result 0x0000.
